l2_mesi_cache_ctrl: RTL and testbench
=====================================

// Module: l2_mesi_cache_ctrl
// PURPOSE
//  Clocked, parameterised set-associative L2 tag/state controller. Holds per-line tag, MESI state and true-LRU rank.
//  Serves CPU read/write and bus-snoop commands over a valid/ready request port, and sequences evict/fill traffic on
//  a req/ack bus port. Sits between the L1 request path and the system bus model; stores tags only, no line data.
// PARAMETERS
//  ADDR_W   32  physical address width
//  SETS     64  number of sets (power of 2); IDX_W=clog2(SETS)
//  WAYS     8   associativity (power of 2, >=2); LRU_W=clog2(WAYS)
//  LINE_B   64  line size in bytes (power of 2); OFF_W=clog2(LINE_B), TAG_W=ADDR_W-IDX_W-OFF_W
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       command valid
//  req_ready    out  1       controller can accept (high only in IDLE)
//  req_cmd      in   3       0 RD, 1 WR, 2 SNP_RD, 3 SNP_RFO, 4 SNP_INV, 5 CLR, 6-7 reserved (NOP response)
//  req_addr     in   ADDR_W  byte address; offset bits ignored
//  resp_valid   out  1       one-cycle completion pulse, no backpressure
//  resp_hit     out  1       tag matched a non-I line at lookup
//  resp_snoop   out  2       snoop reply: 0 NOHIT, 2 HIT, 3 HITM (0 for CPU cmds)
//  bus_req      out  1       bus transaction request, held until bus_ack
//  bus_op       out  2       0 READ, 1 WRITE (writeback), 2 RFO
//  bus_addr     out  ADDR_W  line-aligned address (offset bits zero)
//  bus_ack      in   1       transaction complete this cycle
//  bus_snoop    in   2       others' snoop result, sampled with bus_ack on READ
// BEHAVIOUR
//  Reset: all lines I, LRU rank of way w = w, FSM IDLE; req_ready=1, resp_valid=0, resp_hit=0, resp_snoop=0,
//   bus_req=0, bus_op=0, bus_addr=0. Reset mid-transaction aborts immediately; no partial update survives.
//  FSM: IDLE -(req_valid&req_ready)-> LOOKUP (CLR -> CLEAR); LOOKUP -> RESP | EVICT | FILL | SNPWB;
//   EVICT -(ack)-> FILL; FILL -(ack)-> RESP; SNPWB -(ack)-> RESP; CLEAR -(set SETS-1 done)-> RESP; RESP -> IDLE.
//  Latency: accept at edge N, lookup in N+1, resp_valid during N+2 on a no-bus path; each bus phase adds
//   >=1 cycle (bus_req rises the cycle after the state is entered, drops the cycle after bus_ack).
//  bus_op/bus_addr stable while bus_req=1. bus_ack while bus_req=0 is ignored.
//  Victim select: lowest-index I way; else way with rank WAYS-1.
//  LRU (CPU cmds only, hit or fill): ways ranked below accessed way's old rank increment; accessed way -> 0.
//   Ranks always a permutation of 0..WAYS-1. Snoops never touch LRU.
//  RD hit: state unchanged. RD miss: victim M -> EVICT (WRITE victim addr); then FILL READ;
//   bus_snoop HIT/HITM -> S, NOHIT -> E.
//  WR hit: M->M, E->M with no bus; S -> FILL with RFO, -> M. WR miss: evict as above, RFO, -> M.
//  SNP_RD: M -> SNPWB WRITE, ->S, HITM; E->S HIT; S->S HIT; miss NOHIT.
//  SNP_RFO: M -> SNPWB WRITE, ->I, HITM; E/S ->I HIT; miss NOHIT.
//  SNP_INV: S->I HIT; E/M unchanged HIT/HITM (protocol error, no bus); miss NOHIT.
//  CLR: one set per cycle, all ways -> I (M dropped, no writeback), LRU reset; SETS cycles busy.
//  resp_hit/resp_snoop valid only with resp_valid; zero otherwise.
//  Reserved cmd: no state change, resp_valid at N+2 with hit=0.
// TESTING (defaults: OFF_W=6, IDX_W=6, TAG_W=20)
//  1 RD 0x0000_1040 after reset -> bus READ 0x0000_1040, ack with bus_snoop=0 -> resp hit=0, line E; repeat RD ->
//    resp hit=1 at N+2, bus_req stays 0.
//  2 WR 0x1040 (E) -> hit=1, no bus, M; SNP_RD 0x1040 -> bus WRITE 0x1040, resp_snoop=3, line S.
//  3 RD 0x1040..0x8040 (step 0x1000, set 1, 8 ways) then WR 0x1040, then RD 0x9040 -> victim is tag 2:
//    bus READ 0x9040 only; next RD 0x9040 hit=1.
//  4 Line S at 0x2080, WR 0x2080 -> bus RFO 0x2080, line M; SNP_RFO 0x2080 -> WRITE, HITM, then RD misses.
//  5 CLR -> req_ready=0 for SETS+2 cycles, then RD 0x1040 -> hit=0.
//  6 rst_n low while bus_req=1 in FILL -> bus_req=0, req_ready=1 same cycle; RD after release misses.

Source files
------------

// File: rtl/l2_mesi_cache_ctrl_if.sv
// Request/response and system-bus signal bundle for the L2 MESI tag/state controller.
interface l2_mesi_cache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic [1:0]        resp_snoop;
    logic              bus_req;
    logic [1:0]        bus_op;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ack;
    logic [1:0]        bus_snoop;

    // Requester / bus-model side
    modport master (
        output req_valid, req_cmd, req_addr, bus_ack, bus_snoop,
        input  req_ready, resp_valid, resp_hit, resp_snoop, bus_req, bus_op, bus_addr
    );

    // Controller side
    modport slave (
        input  req_valid, req_cmd, req_addr, bus_ack, bus_snoop,
        output req_ready, resp_valid, resp_hit, resp_snoop, bus_req, bus_op, bus_addr
    );
endinterface

// File: rtl/l2_mesi_cache_ctrl.sv
// Set-associative L2 tag/MESI-state controller with true-LRU ranks. Tags only, no data.
// CPU and snoop commands arrive on a valid/ready port; evict/fill/writeback go out on a req/ack bus.
module l2_mesi_cache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 64,
    parameter int WAYS   = 8,
    parameter int LINE_B = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    l2_mesi_cache_ctrl_if.slave  ctrl_if
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int LRU_W  = $clog2(WAYS);
    localparam int OFF_W  = $clog2(LINE_B);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_t;
    typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_RESP, ST_EVICT, ST_FILL, ST_SNPWB, ST_CLEAR} fsm_t;
    typedef enum logic [2:0] {CMD_RD, CMD_WR, CMD_SNP_RD, CMD_SNP_RFO, CMD_SNP_INV, CMD_CLR,
                              CMD_RSV6, CMD_RSV7} cmd_t;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RFO = 2'd2} op_t;

    logic [TAG_W-1:0] tag_q  [SETS][WAYS];
    mesi_t            line_q [SETS][WAYS];
    logic [LRU_W-1:0] rank_q [SETS][WAYS];

    fsm_t              state_q;
    cmd_t              cmd_q;
    logic [LINE_W-1:0] lk_line;
    logic [LRU_W-1:0]  way_q;
    logic              hit_q;
    logic [IDX_W-1:0]  clr_idx;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, vic_found, lru_en;
    logic [LRU_W-1:0]  hit_way, vic_way, lru_way, victim, lru_sel;
    mesi_t             hit_st, vic_st;
    logic [1:0]        snp_code;

    assign idx = lk_line[IDX_W-1:0];
    assign tag = lk_line[LINE_W-1 -: TAG_W];

    // Tag match, victim choice (first invalid way, else rank WAYS-1) and LRU-update enable
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        vic_found = 1'b0;
        vic_way   = '0;
        lru_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && line_q[idx][w] != MESI_I && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = LRU_W'(w);
            end
            if (!vic_found && line_q[idx][w] == MESI_I) begin
                vic_found = 1'b1;
                vic_way   = LRU_W'(w);
            end
            if (rank_q[idx][w] == LRU_W'(WAYS - 1))
                lru_way = LRU_W'(w);
        end
        victim   = vic_found ? vic_way : lru_way;
        hit_st   = line_q[idx][hit_way];
        vic_st   = line_q[idx][victim];
        snp_code = !hit ? 2'd0 : (hit_st == MESI_M ? 2'd3 : 2'd2);
        // CPU accesses touch LRU on a no-bus hit at lookup, or when their fill completes
        lru_en   = (state_q == ST_LOOKUP && hit &&
                    (cmd_q == CMD_RD || (cmd_q == CMD_WR && hit_st != MESI_S))) ||
                   (state_q == ST_FILL && ctrl_if.bus_req && ctrl_if.bus_ack);
        lru_sel  = (state_q == ST_LOOKUP) ? hit_way : way_q;
    end

    // Controller FSM with registered outputs; owns tag, state and LRU arrays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            cmd_q              <= CMD_RD;
            lk_line            <= '0;
            way_q              <= '0;
            hit_q              <= 1'b0;
            clr_idx            <= '0;
            ctrl_if.req_ready  <= 1'b1;
            ctrl_if.resp_valid <= 1'b0;
            ctrl_if.resp_hit   <= 1'b0;
            ctrl_if.resp_snoop <= '0;
            ctrl_if.bus_req    <= 1'b0;
            ctrl_if.bus_op     <= '0;
            ctrl_if.bus_addr   <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    line_q[s][w] <= MESI_I;
                    rank_q[s][w] <= LRU_W'(w);
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_if.req_valid && ctrl_if.req_ready) begin
                        cmd_q             <= cmd_t'(ctrl_if.req_cmd);
                        lk_line           <= ctrl_if.req_addr[ADDR_W-1:OFF_W];
                        ctrl_if.req_ready <= 1'b0;
                        state_q           <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : victim;
                    // Default outcome is a no-bus response; bus paths override state below
                    state_q            <= ST_RESP;
                    ctrl_if.resp_valid <= 1'b1;
                    ctrl_if.resp_hit   <= hit;
                    ctrl_if.resp_snoop <= '0;
                    case (cmd_q)
                        CMD_RD, CMD_WR: begin
                            if (!hit) begin
                                ctrl_if.resp_valid <= 1'b0;
                                state_q <= (vic_st == MESI_M) ? ST_EVICT : ST_FILL;
                            end else if (cmd_q == CMD_WR) begin
                                if (hit_st == MESI_S) begin
                                    ctrl_if.resp_valid <= 1'b0;
                                    state_q <= ST_FILL;
                                end else begin
                                    line_q[idx][hit_way] <= MESI_M;
                                end
                            end
                        end
                        CMD_SNP_RD, CMD_SNP_RFO, CMD_SNP_INV: begin
                            ctrl_if.resp_snoop <= snp_code;
                            if (hit && hit_st == MESI_M && cmd_q != CMD_SNP_INV) begin
                                ctrl_if.resp_valid <= 1'b0;
                                ctrl_if.resp_snoop <= '0;
                                state_q <= ST_SNPWB;
                            end else if (hit) begin
                                if (cmd_q == CMD_SNP_RD)
                                    line_q[idx][hit_way] <= MESI_S;
                                else if (cmd_q == CMD_SNP_RFO || hit_st == MESI_S)
                                    line_q[idx][hit_way] <= MESI_I;
                            end
                        end
                        CMD_CLR: begin
                            ctrl_if.resp_valid <= 1'b0;
                            clr_idx <= '0;
                            state_q <= ST_CLEAR;
                        end
                        default: ctrl_if.resp_hit <= 1'b0;
                    endcase
                end
                ST_EVICT: begin
                    if (!ctrl_if.bus_req) begin
                        ctrl_if.bus_req  <= 1'b1;
                        ctrl_if.bus_op   <= OP_WRITE;
                        ctrl_if.bus_addr <= {tag_q[idx][way_q], idx, {OFF_W{1'b0}}};
                    end else if (ctrl_if.bus_ack) begin
                        ctrl_if.bus_req <= 1'b0;
                        state_q         <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!ctrl_if.bus_req) begin
                        ctrl_if.bus_req  <= 1'b1;
                        ctrl_if.bus_op   <= (cmd_q == CMD_WR) ? OP_RFO : OP_READ;
                        ctrl_if.bus_addr <= {lk_line, {OFF_W{1'b0}}};
                    end else if (ctrl_if.bus_ack) begin
                        ctrl_if.bus_req     <= 1'b0;
                        tag_q[idx][way_q]   <= tag;
                        line_q[idx][way_q]  <= (cmd_q == CMD_WR) ? MESI_M :
                                               (ctrl_if.bus_snoop != 2'd0) ? MESI_S : MESI_E;
                        ctrl_if.resp_valid  <= 1'b1;
                        ctrl_if.resp_hit    <= hit_q;
                        ctrl_if.resp_snoop  <= '0;
                        state_q             <= ST_RESP;
                    end
                end
                ST_SNPWB: begin
                    if (!ctrl_if.bus_req) begin
                        ctrl_if.bus_req  <= 1'b1;
                        ctrl_if.bus_op   <= OP_WRITE;
                        ctrl_if.bus_addr <= {lk_line, {OFF_W{1'b0}}};
                    end else if (ctrl_if.bus_ack) begin
                        ctrl_if.bus_req    <= 1'b0;
                        line_q[idx][way_q] <= (cmd_q == CMD_SNP_RD) ? MESI_S : MESI_I;
                        ctrl_if.resp_valid <= 1'b1;
                        ctrl_if.resp_hit   <= 1'b1;
                        ctrl_if.resp_snoop <= 2'd3;
                        state_q            <= ST_RESP;
                    end
                end
                ST_CLEAR: begin
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        line_q[clr_idx][w] <= MESI_I;
                        rank_q[clr_idx][w] <= LRU_W'(w);
                    end
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IDX_W'(SETS - 1)) begin
                        ctrl_if.resp_valid <= 1'b1;
                        ctrl_if.resp_hit   <= 1'b0;
                        ctrl_if.resp_snoop <= '0;
                        state_q            <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ctrl_if.resp_valid <= 1'b0;
                    ctrl_if.resp_hit   <= 1'b0;
                    ctrl_if.resp_snoop <= '0;
                    ctrl_if.req_ready  <= 1'b1;
                    state_q            <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // True-LRU: ways younger than the accessed way age by one, accessed way becomes 0
            if (lru_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (LRU_W'(w) == lru_sel)
                        rank_q[idx][w] <= '0;
                    else if (rank_q[idx][w] < rank_q[idx][lru_sel])
                        rank_q[idx][w] <= rank_q[idx][w] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_mesi_cache_ctrl.sv
// Directed self-checking bench for l2_mesi_cache_ctrl (default geometry: 64 sets, 8 ways, 64 B lines).
module tb_l2_mesi_cache_ctrl;
    localparam int ADDR_W = 32;
    localparam int SETS   = 64;

    localparam logic [2:0] RD = 3'd0, WR = 3'd1, SNP_RD = 3'd2, SNP_RFO = 3'd3,
                           SNP_INV = 3'd4, CLR = 3'd5, RSV = 3'd6;
    localparam logic [1:0] OPR = 2'd0, OPW = 2'd1, OPF = 2'd2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l2_mesi_cache_ctrl_if #(.ADDR_W(ADDR_W)) ctrl_if ();

    l2_mesi_cache_ctrl #(.ADDR_W(ADDR_W), .SETS(SETS), .WAYS(8), .LINE_B(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_if (ctrl_if)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        ctrl_if.req_valid = 1'b0;
        ctrl_if.req_cmd   = '0;
        ctrl_if.req_addr  = '0;
        ctrl_if.bus_ack   = 1'b0;
        ctrl_if.bus_snoop = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Present one command for one cycle once the controller is ready; returns on the negedge after acceptance
    task automatic do_req(input logic [2:0] cmd, input logic [31:0] addr);
        int n = 0;
        while (!ctrl_if.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        ctrl_if.req_valid = 1'b1;
        ctrl_if.req_cmd   = cmd;
        ctrl_if.req_addr  = addr;
        @(negedge clk);
        ctrl_if.req_valid = 1'b0;
    endtask

    // Wait (bounded) for one bus request, capture it and acknowledge it for one cycle
    task automatic serve_bus(input logic [1:0] snp, output logic [1:0] op,
                             output logic [31:0] addr, output bit seen);
        int n = 0;
        seen = 1'b0;
        op   = 2'bxx;
        addr = 'x;
        while (!ctrl_if.bus_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ctrl_if.bus_req) begin
            seen = 1'b1;
            op   = ctrl_if.bus_op;
            addr = ctrl_if.bus_addr;
            ctrl_if.bus_ack   = 1'b1;
            ctrl_if.bus_snoop = snp;
            @(negedge clk);
            ctrl_if.bus_ack   = 1'b0;
            ctrl_if.bus_snoop = '0;
        end
    endtask

    // Wait (bounded) for the response pulse; lat counts negedges waited, bus_seen flags any bus_req meanwhile
    task automatic wait_resp(output logic hit, output logic [1:0] snp, output int lat,
                             output bit bus_seen, output bit seen);
        lat = 0;
        bus_seen = 1'b0;
        seen = 1'b0;
        hit = 1'bx;
        snp = 2'bxx;
        while (!ctrl_if.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ctrl_if.bus_req) bus_seen = 1'b1;
        end
        if (ctrl_if.resp_valid) begin
            seen = 1'b1;
            hit  = ctrl_if.resp_hit;
            snp  = ctrl_if.resp_snoop;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (ctrl_if.req_ready !== 1'b1 || ctrl_if.resp_valid !== 1'b0 || ctrl_if.resp_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_resp: ready=%b valid=%b hit=%b, expected 1 0 0",
                     ctrl_if.req_ready, ctrl_if.resp_valid, ctrl_if.resp_hit);
        end
        checks++;
        if (ctrl_if.resp_snoop !== 2'd0 || ctrl_if.bus_req !== 1'b0 || ctrl_if.bus_op !== 2'd0 ||
            ctrl_if.bus_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: snoop=%0d req=%b op=%0d addr=%h, expected 0 0 0 0",
                     ctrl_if.resp_snoop, ctrl_if.bus_req, ctrl_if.bus_op, ctrl_if.bus_addr);
        end
    endtask

    // RD miss fills E via bus READ; repeat RD hits with minimum latency and no bus activity
    task automatic test_rd_fill();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        do_req(RD, 32'h0000_1040);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_1040) begin
            errors++;
            $display("FAIL rd_miss_bus: seen=%b op=%0d addr=%h, expected 1 0 00001040", bs, op, a);
        end
        checks++;
        if (!rs || hit !== 1'b0 || snp !== 2'd0) begin
            errors++;
            $display("FAIL rd_miss_resp: seen=%b hit=%b snoop=%0d, expected 1 0 0", rs, hit, snp);
        end
        do_req(RD, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || lat != 1 || bseen) begin
            errors++;
            $display("FAIL rd_hit: seen=%b hit=%b lat=%0d bus=%b, expected 1 1 1 0", rs, hit, lat, bseen);
        end
    endtask

    // WR on E upgrades silently to M; SNP_RD on M writes back, answers HITM and leaves S
    task automatic test_wr_snoop();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        do_req(WR, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || lat != 1 || bseen) begin
            errors++;
            $display("FAIL wr_hit_e: seen=%b hit=%b lat=%0d bus=%b, expected 1 1 1 0", rs, hit, lat, bseen);
        end
        do_req(SNP_RD, 32'h0000_1040);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPW || a !== 32'h0000_1040) begin
            errors++;
            $display("FAIL snprd_m_bus: seen=%b op=%0d addr=%h, expected 1 1 00001040", bs, op, a);
        end
        checks++;
        if (!rs || hit !== 1'b1 || snp !== 2'd3) begin
            errors++;
            $display("FAIL snprd_m_resp: seen=%b hit=%b snoop=%0d, expected 1 1 3", rs, hit, snp);
        end
        do_req(SNP_RD, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || snp !== 2'd2 || bseen) begin
            errors++;
            $display("FAIL snprd_s: seen=%b hit=%b snoop=%0d bus=%b, expected 1 1 2 0", rs, hit, snp, bseen);
        end
    endtask

    // Fill all 8 ways of set 1, touch tag 1, then the next miss must replace tag 2 (clean, no writeback)
    task automatic test_victim();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            do_req(RD, 32'(k) * 32'h1000 + 32'h40);
            serve_bus(2'd0, op, a, bs);
            wait_resp(hit, snp, lat, bseen, rs);
        end
        do_req(WR, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || bseen) begin
            errors++;
            $display("FAIL victim_wr_touch: seen=%b hit=%b bus=%b, expected 1 1 0", rs, hit, bseen);
        end
        do_req(RD, 32'h0000_9040);
        serve_bus(2'd0, op, a, bs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_9040) begin
            errors++;
            $display("FAIL victim_first_bus: seen=%b op=%0d addr=%h, expected 1 0 00009040", bs, op, a);
        end
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b0) begin
            errors++;
            $display("FAIL victim_miss_resp: seen=%b hit=%b, expected 1 0", rs, hit);
        end
        do_req(RD, 32'h0000_9040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || bseen) begin
            errors++;
            $display("FAIL victim_new_hit: seen=%b hit=%b bus=%b, expected 1 1 0", rs, hit, bseen);
        end
        do_req(RD, 32'h0000_2040);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_2040 || hit !== 1'b0) begin
            errors++;
            $display("FAIL victim_tag2_gone: op=%0d addr=%h hit=%b, expected 0 00002040 0", op, a, hit);
        end
        do_req(RD, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || bseen) begin
            errors++;
            $display("FAIL victim_mru_kept: seen=%b hit=%b bus=%b, expected 1 1 0", rs, hit, bseen);
        end
    endtask

    // S line upgraded by RFO; SNP_RFO on M writes back with HITM and invalidates
    task automatic test_rfo();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        apply_reset();
        do_req(RD, 32'h0000_2080);
        serve_bus(2'd2, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        do_req(WR, 32'h0000_2080);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPF || a !== 32'h0000_2080 || hit !== 1'b1) begin
            errors++;
            $display("FAIL rfo_upgrade: seen=%b op=%0d addr=%h hit=%b, expected 1 2 00002080 1", bs, op, a, hit);
        end
        do_req(SNP_RFO, 32'h0000_2080);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPW || a !== 32'h0000_2080 || snp !== 2'd3 || hit !== 1'b1) begin
            errors++;
            $display("FAIL snprfo_m: seen=%b op=%0d addr=%h snoop=%0d hit=%b, expected 1 1 00002080 3 1",
                     bs, op, a, snp, hit);
        end
        do_req(RD, 32'h0000_2080);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPR || hit !== 1'b0) begin
            errors++;
            $display("FAIL rfo_after_inval: seen=%b op=%0d hit=%b, expected 1 0 0", bs, op, hit);
        end
    endtask

    // Line 0x2080 is E here: SNP_INV leaves E, SNP_RFO invalidates, then snoop miss and reserved command
    task automatic test_snoop_misc();
        logic [1:0] snp; bit rs, bseen; logic hit; int lat;
        do_req(SNP_INV, 32'h0000_2080);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || snp !== 2'd2 || bseen) begin
            errors++;
            $display("FAIL snpinv_e: seen=%b hit=%b snoop=%0d bus=%b, expected 1 1 2 0", rs, hit, snp, bseen);
        end
        do_req(SNP_RFO, 32'h0000_2080);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b1 || snp !== 2'd2 || bseen) begin
            errors++;
            $display("FAIL snprfo_e: seen=%b hit=%b snoop=%0d bus=%b, expected 1 1 2 0", rs, hit, snp, bseen);
        end
        do_req(SNP_RD, 32'h0000_2080);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b0 || snp !== 2'd0 || bseen) begin
            errors++;
            $display("FAIL snprd_miss: seen=%b hit=%b snoop=%0d bus=%b, expected 1 0 0 0", rs, hit, snp, bseen);
        end
        do_req(RSV, 32'h0000_1040);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b0 || snp !== 2'd0 || lat != 1 || bseen) begin
            errors++;
            $display("FAIL reserved_cmd: seen=%b hit=%b snoop=%0d lat=%0d bus=%b, expected 1 0 0 1 0",
                     rs, hit, snp, lat, bseen);
        end
    endtask

    // Eight WR misses make set 3 all-M; the ninth miss writes back the LRU (tag 1) before filling
    task automatic test_evict_dirty();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        apply_reset();
        for (int k = 1; k <= 8; k++) begin
            do_req(WR, 32'(k) * 32'h1000 + 32'hC0);
            serve_bus(2'd0, op, a, bs);
            wait_resp(hit, snp, lat, bseen, rs);
        end
        checks++;
        if (!bs || op !== OPF || a !== 32'h0000_80C0) begin
            errors++;
            $display("FAIL wr_miss_rfo: seen=%b op=%0d addr=%h, expected 1 2 000080c0", bs, op, a);
        end
        do_req(RD, 32'h0000_90C0);
        serve_bus(2'd0, op, a, bs);
        checks++;
        if (!bs || op !== OPW || a !== 32'h0000_10C0) begin
            errors++;
            $display("FAIL evict_wb: seen=%b op=%0d addr=%h, expected 1 1 000010c0", bs, op, a);
        end
        serve_bus(2'd0, op, a, bs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_90C0) begin
            errors++;
            $display("FAIL evict_fill: seen=%b op=%0d addr=%h, expected 1 0 000090c0", bs, op, a);
        end
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!rs || hit !== 1'b0) begin
            errors++;
            $display("FAIL evict_resp: seen=%b hit=%b, expected 1 0", rs, hit);
        end
    endtask

    // CLR keeps the port busy SETS+2 cycles and invalidates everything, dirty lines included
    task automatic test_clear();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        int busy = 0;
        do_req(CLR, 32'h0);
        while (!ctrl_if.req_ready && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        checks++;
        if (busy != SETS + 2) begin
            errors++;
            $display("FAIL clr_busy: ready low %0d cycles, expected %0d", busy, SETS + 2);
        end
        do_req(RD, 32'h0000_90C0);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_90C0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL clr_then_miss: seen=%b op=%0d addr=%h hit=%b, expected 1 0 000090c0 0", bs, op, a, hit);
        end
    endtask

    // Reset asserted while a fill is on the bus drops bus_req and raises req_ready immediately
    task automatic test_reset_mid();
        logic [1:0] op, snp; logic [31:0] a; bit bs, rs, bseen; logic hit; int lat;
        int n = 0;
        do_req(RD, 32'h0000_3100);
        while (!ctrl_if.bus_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ctrl_if.bus_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill_req: bus_req=%b, expected 1", ctrl_if.bus_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ctrl_if.bus_req !== 1'b0 || ctrl_if.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_async: bus_req=%b ready=%b, expected 0 1", ctrl_if.bus_req, ctrl_if.req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(RD, 32'h0000_3100);
        serve_bus(2'd0, op, a, bs);
        wait_resp(hit, snp, lat, bseen, rs);
        checks++;
        if (!bs || op !== OPR || a !== 32'h0000_3100 || hit !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_miss: seen=%b op=%0d addr=%h hit=%b, expected 1 0 00003100 0", bs, op, a, hit);
        end
    endtask

    initial begin
        test_reset();
        test_rd_fill();
        test_wr_snoop();
        test_victim();
        test_rfo();
        test_snoop_misc();
        test_evict_dirty();
        test_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
